// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and flag types for the sequential ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_NOT = 4'b0101,
        OP_SHL = 4'b0110,
        OP_SHR = 4'b0111,
        OP_SAR = 4'b1000,
        OP_MUL = 4'b1001
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic negative;
        logic zero;
        logic illegal;
    } flags_t;

    function automatic flags_t make_flags(input logic cout_v, input logic ovf_v,
                                          input logic neg_v, input logic zero_v,
                                          input logic ill_v);
        flags_t f;
        f.cout     = cout_v;
        f.overflow = ovf_v;
        f.negative = neg_v;
        f.zero     = zero_v;
        f.illegal  = ill_v;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle ops (add/sub/logic) and their flags
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] y_o,
    output flags_t           flags_o
);

    logic [WIDTH:0] sum_w;
    logic           cout_w;
    logic           ovf_w;
    logic           ill_w;

    // Evaluate the op; anything not handled here reports illegal with y=0
    always_comb begin
        sum_w  = '0;
        y_o    = '0;
        cout_w = 1'b0;
        ovf_w  = 1'b0;
        ill_w  = 1'b0;
        case (op_i)
            OP_ADD: begin
                sum_w  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
                y_o    = sum_w[WIDTH-1:0];
                cout_w = sum_w[WIDTH];
                ovf_w  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is set exactly when a < b+cin
                sum_w  = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
                y_o    = sum_w[WIDTH-1:0];
                cout_w = sum_w[WIDTH];
                ovf_w  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NOT:  y_o = ~a_i;
            default: ill_w = 1'b1;
        endcase
    end

    // Zero is suppressed for illegal ops even though y is 0
    assign flags_o = make_flags(cout_w, ovf_w, y_o[WIDTH-1], (y_o == '0) && !ill_w, ill_w);

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative shifts and shift-add multiply
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             illegal
);

    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW:0]    MUL_ITERS = (CW+1)'(WIDTH);
    localparam logic [CW:0]    LAST_ITER = {{CW{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;       // shift value, or low product / multiplier
    logic [WIDTH-1:0] hi_q, hi_d;         // high product half
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    flags_t           flags_q, flags_d;

    logic             accept;
    logic             is_shift;
    logic             is_mul;
    logic [CW-1:0]    sh_cnt;
    logic [WIDTH-1:0] core_y;
    flags_t           core_flags;

    logic [WIDTH:0]   madd;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_hi;
    logic             step_cout;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i    (opcode),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .y_o     (core_y),
        .flags_o (core_flags)
    );

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign sh_cnt   = b[CW-1:0];
    assign is_shift = (opcode == OP_SHL) || (opcode == OP_SHR) || (opcode == OP_SAR);
    assign is_mul   = (opcode == OP_MUL) && MUL_EN;

    // One iteration of the running shift or multiply
    always_comb begin
        madd      = '0;
        step_acc  = acc_q;
        step_hi   = hi_q;
        step_cout = 1'b0;
        case (op_q)
            OP_SHL: begin
                step_acc  = {acc_q[WIDTH-2:0], 1'b0};
                step_cout = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                step_acc  = {1'b0, acc_q[WIDTH-1:1]};
                step_cout = acc_q[0];
            end
            OP_SAR: begin
                step_acc  = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                step_cout = acc_q[0];
            end
            default: begin
                // Add multiplicand when the current multiplier LSB is set, then
                // shift the {hi,acc} pair right so acc ends up as the low product
                madd     = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
                step_hi  = madd[WIDTH:1];
                step_acc = {madd[0], acc_q[WIDTH-1:1]};
            end
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        flags_d = flags_q;
        case (state_q)
            ST_BUSY: begin
                acc_d = step_acc;
                hi_d  = step_hi;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                    y_d     = step_acc;
                    if (op_q == OP_MUL) begin
                        flags_d = make_flags(1'b0, step_hi != '0, step_acc[WIDTH-1],
                                             step_acc == '0, 1'b0);
                    end else begin
                        flags_d = make_flags(step_cout, 1'b0, step_acc[WIDTH-1],
                                             step_acc == '0, 1'b0);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            op_d    = opcode;
            mcand_d = a;
            hi_d    = '0;
            if (is_shift && (sh_cnt != '0)) begin
                state_d = ST_BUSY;
                acc_d   = a;
                cnt_d   = {1'b0, sh_cnt};
            end else if (is_mul) begin
                state_d = ST_BUSY;
                acc_d   = b;
                cnt_d   = MUL_ITERS;
            end else if (is_shift) begin
                state_d = ST_DONE;
                y_d     = a;
                flags_d = make_flags(1'b0, 1'b0, a[WIDTH-1], a == '0, 1'b0);
            end else begin
                state_d = ST_DONE;
                y_d     = core_y;
                flags_d = core_flags;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;
    assign cout      = flags_q.cout;
    assign overflow  = flags_q.overflow;
    assign negative  = flags_q.negative;
    assign zero      = flags_q.zero;
    assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=4)
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic       cout;
    logic       overflow;
    logic       negative;
    logic       zero;
    logic       illegal;

    int tests = 0;
    int fails = 0;
    int lat;

    alu_seq #(.WIDTH(4), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .overflow  (overflow),
        .negative  (negative),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] flags();
        return {cout, overflow, negative, zero, illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] av, input logic [3:0] bv,
                         input logic ci, input string tag);
        opcode   = op;
        a        = av;
        b        = bv;
        cin      = ci;
        in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 4'hx;
        b        = 4'hx;
    endtask

    task automatic wait_result(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!out_valid && l < 20);
    endtask

    task automatic run(input logic [3:0] op, input logic [3:0] av, input logic [3:0] bv,
                       input logic ci, input int exp_lat, input logic [3:0] exp_y,
                       input logic [4:0] exp_f, input string tag);
        int l;
        issue(op, av, bv, ci, tag);
        wait_result(l);
        check({tag, " latency"}, 32'(l), 32'(exp_lat));
        check({tag, " y"}, 32'(y), 32'(exp_y));
        check({tag, " flags"}, 32'(flags()), 32'(exp_f));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = 4'h0;
        a         = 4'h0;
        b         = 4'h0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset y", 32'(y), 32'd0);
        check("reset flags", 32'(flags()), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // flags order: {cout, overflow, negative, zero, illegal}
        run(4'b0000, 4'b0001, 4'b0001, 1'b0, 1, 4'b0010, 5'b00000, "add_1_1");
        run(4'b0000, 4'b0111, 4'b0001, 1'b0, 1, 4'b1000, 5'b01100, "add_ovf");
        run(4'b0001, 4'b0000, 4'b0001, 1'b0, 1, 4'b1111, 5'b10100, "sub_borrow");
        run(4'b0000, 4'b1111, 4'b0000, 1'b1, 1, 4'b0000, 5'b10010, "add_cin_wrap");
        run(4'b0001, 4'b0101, 4'b0010, 1'b1, 1, 4'b0010, 5'b00000, "sub_cin");
        run(4'b0111, 4'b0110, 4'b0010, 1'b0, 3, 4'b0001, 5'b10000, "shr_2");
        run(4'b0110, 4'b0011, 4'b0000, 1'b0, 1, 4'b0011, 5'b00000, "shl_0");
        run(4'b0110, 4'b1001, 4'b0101, 1'b0, 2, 4'b0010, 5'b10000, "shl_mod");
        run(4'b1000, 4'b1000, 4'b0001, 1'b0, 2, 4'b1100, 5'b00100, "sar_1");
        run(4'b1001, 4'b0101, 4'b0011, 1'b0, 5, 4'b1111, 5'b00100, "mul_5x3");
        run(4'b1001, 4'b0100, 4'b0100, 1'b0, 5, 4'b0000, 5'b01010, "mul_4x4");
        run(4'b0101, 4'b1010, 4'b0000, 1'b0, 1, 4'b0101, 5'b00000, "not");

        // Backpressure: result must hold while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        run(4'b0010, 4'b1100, 4'b1010, 1'b0, 1, 4'b1000, 5'b00100, "and_hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold y", 32'(y), 32'h8);
            check("hold flags", 32'(flags()), 32'(5'b00100));
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        run(4'b0100, 4'b1100, 4'b1010, 1'b0, 1, 4'b0110, 5'b00000, "xor_b2b");

        // Reset in the middle of a multiply abandons it
        issue(4'b1001, 4'b0011, 4'b0011, 1'b0, "mul_abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort y", 32'(y), 32'd0);
        reset = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        check("abort no result", 32'(lat), 32'd0);

        run(4'b1111, 4'b0101, 4'b0011, 1'b0, 1, 4'b0000, 5'b00001, "illegal_f");
        run(4'b1010, 4'b0000, 4'b0000, 1'b0, 1, 4'b0000, 5'b00001, "illegal_a");
        run(4'b0000, 4'b0010, 4'b0011, 1'b0, 1, 4'b0101, 5'b00000, "add_after_ill");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequential, handshaked successor to the combinational `alu`.
- Parametrised width; results and flags are registered.
- Accepts one operation at a time over a valid/ready input channel and returns the result and flags over a valid/ready output channel.
- Single-cycle ops (add/sub/logic) complete in 1 cycle; shifts run 1 bit/cycle and multiply runs shift-add iteratively, so the block is small enough for the datapath-slice level of the design.

Parameters:
- WIDTH, 4, operand/result width; power of two, ≥4.
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL decodes as illegal.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation.
- opcode  input  4  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; low $clog2(WIDTH) bits are the shift count for shifts.
- cin  input  1  carry-in (ADD) / borrow-in (SUB).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- y  output  WIDTH  result.
- cout  output  1  carry/borrow/last-bit-out.
- overflow  output  1  signed overflow (ADD/SUB), high-half-nonzero (MUL).
- negative  output  1  y[WIDTH-1].
- zero  output  1  y == 0.
- illegal  output  1  opcode not implemented.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, all flags 0.
- Reset mid-operation abandons the op; no result is produced.
- Opcodes:
  - 0000 ADD: y = a+b+cin.
  - 0001 SUB: y = a−b−cin.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 NOT a.
  - 0110 SHL.
  - 0111 SHR (logical).
  - 1000 SAR.
  - 1001 MUL.
  - All others illegal.
- Accept: on a rising edge with in_valid && in_ready, latch opcode/a/b/cin.
  - in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back ops are possible.
- FSM:
  - IDLE → DONE for single-cycle and illegal ops, and for shifts with count 0.
  - IDLE → BUSY for shifts with count>0 and for MUL.
  - BUSY → DONE when the iteration counter expires.
  - DONE → IDLE on out_ready without a new accept.
  - DONE → DONE/BUSY when out_ready and a new accept occur in the same cycle.
- Latency (accept edge to the first cycle out_valid=1):
  - Single-cycle ops: 1.
  - Shifts: 1+count.
  - MUL: 1+WIDTH.
- Output hold: out_valid=1 only in DONE. y and flags hold stable while out_valid && !out_ready. in_ready=0 in BUSY.
- Flags:
  - ADD: cout = carry out of bit WIDTH-1; overflow = signed overflow.
  - SUB: cout = borrow, i.e. 1 iff a < b+cin unsigned; overflow = signed overflow.
  - Logic ops: cout=0, overflow=0.
  - Shifts: one bit per BUSY cycle. cout = last bit shifted out (0 when count=0). overflow=0. SAR replicates the MSB.
  - MUL: unsigned shift-add, one partial product per cycle. y = low WIDTH bits. overflow = 1 iff the high WIDTH bits are nonzero. cout=0.
  - negative and zero are always derived from the final y.
- Illegal opcode (including MUL with MUL_EN=0): y=0, illegal=1, other flags 0 (zero=0 in this case). illegal=0 for all legal ops.
- Shift count: b mod WIDTH, using the low $clog2(WIDTH) bits only.
- Input-side rules:
  - in_valid while in_ready=0 is ignored; the producer must hold its inputs.
  - Operand changes after accept have no effect.

Decomposition:
- Package alu_pkg:
  - Opcode enum (`op_e`, 4 bits) with the values above.
  - FSM state enum (IDLE/BUSY/DONE).
  - Flags struct (cout, overflow, negative, zero, illegal).
- Sub-module alu_core: purely combinational single-cycle ops (ADD/SUB/logic) plus flag generation.
- alu_seq holds the FSM, the operand/iteration registers, and the shift/MUL datapath.

Test Plan:
- WIDTH=4, ADD, a=0001, b=0001, cin=0 → one cycle after accept: out_valid=1, y=0010, all flags 0.
- ADD a=0111, b=0001 → y=1000, overflow=1, negative=1, cout=0. Then SUB a=0000, b=0001, cin=0 → y=1111, cout=1, negative=1, overflow=0.
- SHR a=0110, b=0010 → out_valid 3 cycles after accept, y=0001, cout=1. SHL a=0011, b=0000 → 1 cycle, y=0011, cout=0.
- MUL a=0101, b=0011 → out_valid 5 cycles after accept, y=1111, overflow=0. MUL a=0100, b=0100 → y=0000, zero=1, overflow=1.
- Hold out_ready=0 for 5 cycles with a result pending → out_valid, y and flags stable, in_ready=0. Then assert out_ready with in_valid=1 in the same cycle → new op accepted that edge, next result 1 cycle later.
- Assert reset during cycle 2 of a MUL → next cycle out_valid=0, in_ready=1, y=0. Then opcode 1111 → y=0, illegal=1; later ADD → illegal=0.
